// File: rtl/rcv_bit_timer_if.sv
// rtl/rcv_bit_timer_if.sv - line inputs and decoded-bit outputs of the receive bit timer
interface rcv_bit_timer_if;
   logic rcving;
   logic d_plus_sync;
   logic d_minus_sync;
   logic edge_sig;
   logic shift_enable;
   logic d_orig;
   logic byte_received;
   logic eop;
   logic stuff_err;

   modport master (
      output rcving, d_plus_sync, d_minus_sync, edge_sig,
      input  shift_enable, d_orig, byte_received, eop, stuff_err
   );

   modport slave (
      input  rcving, d_plus_sync, d_minus_sync, edge_sig,
      output shift_enable, d_orig, byte_received, eop, stuff_err
   );
endinterface

// File: rtl/rcv_bit_timer.sv
// rtl/rcv_bit_timer.sv - bit-clock recovery, NRZI decode and destuffing for the receive path
module rcv_bit_timer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3,
   parameter int STUFF_LEN    = 6
) (
   input logic           clk,
   input logic           n_rst,
   rcv_bit_timer_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int OW = $clog2(STUFF_LEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t        state, state_n;
   logic [CW-1:0] clk_cnt, clk_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [OW-1:0] ones_cnt, ones_cnt_n;
   logic          prev_raw, prev_raw_n;
   logic          decoded;
   logic          se_q, d_q, br_q, eop_q, serr_q;
   logic          se_n, d_n, br_n, eop_n, serr_n;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state    <= IDLE;
         clk_cnt  <= '0;
         bit_cnt  <= '0;
         ones_cnt <= '0;
         prev_raw <= 1'b1;
         se_q     <= 1'b0;
         d_q      <= 1'b0;
         br_q     <= 1'b0;
         eop_q    <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state    <= state_n;
         clk_cnt  <= clk_cnt_n;
         bit_cnt  <= bit_cnt_n;
         ones_cnt <= ones_cnt_n;
         prev_raw <= prev_raw_n;
         se_q     <= se_n;
         d_q      <= d_n;
         br_q     <= br_n;
         eop_q    <= eop_n;
         serr_q   <= serr_n;
      end
   end

   always_comb begin
      state_n    = state;
      clk_cnt_n  = clk_cnt;
      bit_cnt_n  = bit_cnt;
      ones_cnt_n = ones_cnt;
      prev_raw_n = prev_raw;
      se_n       = 1'b0;
      d_n        = 1'b0;
      br_n       = 1'b0;
      eop_n      = 1'b0;
      serr_n     = 1'b0;
      decoded    = ~(bus.d_plus_sync ^ prev_raw);

      case (state)
         IDLE: begin
            clk_cnt_n  = '0;
            bit_cnt_n  = '0;
            ones_cnt_n = '0;
            prev_raw_n = 1'b1;
            if (bus.rcving) state_n = RUN;
         end
         RUN: begin
            if (!bus.rcving) begin
               state_n = IDLE;
            end else begin
               // A transition re-anchors the bit phase: the edge cycle is phase 0.
               if (bus.edge_sig)
                  clk_cnt_n = CW'(1);
               else if (clk_cnt == CW'(CLKS_PER_BIT - 1))
                  clk_cnt_n = '0;
               else
                  clk_cnt_n = clk_cnt + CW'(1);

               if (!bus.edge_sig && clk_cnt == CW'(SAMPLE_POINT)) begin
                  if (!bus.d_plus_sync && !bus.d_minus_sync) begin
                     eop_n      = 1'b1;
                     ones_cnt_n = '0;
                     bit_cnt_n  = '0;
                     state_n    = HOLD;
                  end else begin
                     prev_raw_n = bus.d_plus_sync;
                     if (ones_cnt == OW'(STUFF_LEN)) begin
                        ones_cnt_n = '0;
                        serr_n     = decoded;
                     end else begin
                        se_n       = 1'b1;
                        d_n        = decoded;
                        ones_cnt_n = decoded ? ones_cnt + OW'(1) : '0;
                        bit_cnt_n  = bit_cnt + 3'd1;
                        br_n       = (bit_cnt == 3'd7);
                     end
                  end
               end
            end
         end
         HOLD: begin
            if (!bus.rcving) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.shift_enable  = se_q;
   assign bus.d_orig        = d_q;
   assign bus.byte_received = br_q;
   assign bus.eop           = eop_q;
   assign bus.stuff_err     = serr_q;
endmodule

// File: tb/tb_rcv_bit_timer.sv
// tb/tb_rcv_bit_timer.sv - scoreboard bench for rcv_bit_timer with directed line patterns
module tb_rcv_bit_timer;
   localparam int K_NONE = 0;
   localparam int K_SE   = 1;
   localparam int K_EOP  = 2;
   localparam int K_ERR  = 3;

   typedef struct {
      int         cyc;
      logic [4:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b1;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   bit   mon_en = 1'b0;
   exp_t q[$];
   exp_t e;
   logic [4:0] act;

   rcv_bit_timer_if bus();

   rcv_bit_timer #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3), .STUFF_LEN(6)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output vector {shift_enable, d_orig, byte_received, eop, stuff_err}
   always @(negedge clk) begin
      if (mon_en) begin
         act = {bus.shift_enable, bus.d_orig & bus.shift_enable, bus.byte_received, bus.eop, bus.stuff_err};
         while (q.size() > 0 && q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_pulse: expected %b at cycle %0d, nothing seen (now %0d)", q[0].v, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (act != 5'b0) begin
            compared++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
               mismatched++;
               $display("FAIL unexpected_pulse: got %b at cycle %0d, required no pulse", act, cyc);
            end else begin
               e = q.pop_front();
               if (act != e.v) begin
                  mismatched++;
                  $display("FAIL pulse_value: got %b at cycle %0d, required %b", act, cyc, e.v);
               end
            end
         end
      end
   end

   task automatic drive_period(input logic dp, input logic dm, input int n,
                               input int kind, input logic d, input logic br);
      exp_t x;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            bus.edge_sig = (dp != bus.d_plus_sync);
            if (kind != K_NONE) begin
               x.cyc = cyc + 4;
               case (kind)
                  K_SE:    x.v = {1'b1, d, br, 2'b00};
                  K_EOP:   x.v = 5'b00010;
                  default: x.v = 5'b00001;
               endcase
               q.push_back(x);
            end
         end else begin
            bus.edge_sig = 1'b0;
         end
         bus.d_plus_sync  = dp;
         bus.d_minus_sync = dm;
      end
   endtask

   task automatic sbit(input logic level, input int kind, input logic d, input logic br);
      drive_period(level, ~level, 8, kind, d, br);
   endtask

   task automatic start_rx();
      @(posedge clk); #1;
      bus.rcving = 1'b1;
      bus.edge_sig = 1'b0;
   endtask

   task automatic stop_rx();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus.rcving = 1'b0;
         bus.edge_sig = 1'b0;
         bus.d_plus_sync = 1'b1;
         bus.d_minus_sync = 1'b0;
      end
   endtask

   task automatic sync_pattern();
      int lv[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
      for (int i = 0; i < 8; i++)
         sbit(lv[i][0], K_SE, (i == 7), (i == 7));
   endtask

   task automatic check_zero(input string name);
      @(negedge clk);
      compared++;
      act = {bus.shift_enable, bus.d_orig, bus.byte_received, bus.eop, bus.stuff_err};
      if (act != 5'b0) begin
         mismatched++;
         $display("FAIL %s: outputs %b, required 00000", name, act);
      end
   endtask

   initial begin
      bus.rcving = 1'b1;
      bus.d_plus_sync = 1'b1;
      bus.d_minus_sync = 1'b0;
      bus.edge_sig = 1'b0;
      n_rst = 1'b1;

      // Reset with lines toggling and rcving high
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         bus.d_plus_sync = ~bus.d_plus_sync;
         bus.d_minus_sync = ~bus.d_plus_sync;
         bus.edge_sig = 1'b1;
         mon_en = 1'b1;
         check_zero("reset_outputs");
      end
      @(posedge clk); #1;
      n_rst = 1'b0;
      bus.rcving = 1'b0;
      bus.edge_sig = 1'b0;
      bus.d_plus_sync = 1'b1;
      bus.d_minus_sync = 1'b0;
      check_zero("post_reset_idle");
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         bus.d_plus_sync = ~bus.d_plus_sync;
         bus.d_minus_sync = ~bus.d_plus_sync;
         bus.edge_sig = 1'b1;
      end
      stop_rx();

      // SYNC, then destuffing of a zero after six ones
      start_rx();
      sync_pattern();
      for (int i = 0; i < 5; i++) sbit(1'b0, K_SE, 1'b1, 1'b0);
      sbit(1'b1, K_NONE, 1'b0, 1'b0);
      sbit(1'b1, K_SE, 1'b1, 1'b0);
      sbit(1'b0, K_SE, 1'b0, 1'b0);
      sbit(1'b0, K_SE, 1'b1, 1'b1);
      stop_rx();

      // Seventh consecutive one is a stuff error; counting restarts after it
      start_rx();
      sync_pattern();
      for (int i = 0; i < 5; i++) sbit(1'b0, K_SE, 1'b1, 1'b0);
      sbit(1'b0, K_ERR, 1'b0, 1'b0);
      sbit(1'b0, K_SE, 1'b1, 1'b0);
      stop_rx();

      // Early edge at clk_cnt=5 re-aligns the sample point
      start_rx();
      sync_pattern();
      drive_period(1'b1, 1'b0, 5, K_SE, 1'b0, 1'b0);
      sbit(1'b0, K_SE, 1'b0, 1'b0);
      sbit(1'b0, K_SE, 1'b1, 1'b0);
      stop_rx();

      // SE0 gives one eop, then the block holds silent until rcving drops
      start_rx();
      sync_pattern();
      sbit(1'b1, K_SE, 1'b0, 1'b0);
      drive_period(1'b0, 1'b0, 16, K_EOP, 1'b0, 1'b0);
      sbit(1'b1, K_NONE, 1'b0, 1'b0);
      sbit(1'b0, K_NONE, 1'b0, 1'b0);
      stop_rx();

      // Reset in the sample cycle of bit 5 of a byte
      start_rx();
      sync_pattern();
      sbit(1'b1, K_SE, 1'b0, 1'b0);
      sbit(1'b1, K_SE, 1'b1, 1'b0);
      sbit(1'b0, K_SE, 1'b0, 1'b0);
      sbit(1'b0, K_SE, 1'b1, 1'b0);
      drive_period(1'b1, 1'b0, 3, K_NONE, 1'b0, 1'b0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      bus.rcving = 1'b0;
      check_zero("reset_midbyte");
      @(posedge clk); #1;
      check_zero("reset_midbyte_hold");
      @(posedge clk); #1;
      n_rst = 1'b0;
      bus.d_plus_sync = 1'b1;
      bus.d_minus_sync = 1'b0;
      stop_rx();
      start_rx();
      sync_pattern();
      stop_rx();

      for (int i = 0; i < 12; i++) @(posedge clk);
      @(negedge clk);
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL queue_drained: %0d expected pulses outstanding, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
